// File: rtl/escalonador_leitura_banco.sv
// Read-port sequencer for the register file: fetches rs, then rt when needed,
// forwarding same-cycle writes, and hands both operands to EX via valid/ready.
module escalonador_leitura_banco (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valido,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic        req_usa_rt,
    output logic        req_pronto,
    input  logic        descarta,
    output logic [4:0]  enderecoLeitura,
    input  logic [31:0] dadosLeitura,
    input  logic        wb_escrita,
    input  logic [4:0]  wb_endereco,
    input  logic [31:0] wb_dados,
    input  logic        link_escrita,
    input  logic [31:0] link_dados,
    output logic        op_valido,
    output logic [31:0] op_rs,
    output logic [31:0] op_rt,
    input  logic        op_pronto,
    output logic        hazard
);
    typedef enum logic [1:0] {OCIOSO, LE_RS, LE_RT, ENTREGA} estado_t;

    estado_t     estado_q, estado_d;
    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic        usa_rt_q, usa_rt_d;
    logic [31:0] op_rs_q, op_rs_d;
    logic [31:0] op_rt_q, op_rt_d;
    logic [4:0]  endereco;
    logic [31:0] valor;

    always_comb begin
        endereco = 5'd0;
        case (estado_q)
            LE_RS:   endereco = rs_q;
            LE_RT:   endereco = rt_q;
            default: endereco = 5'd0;
        endcase
    end

    // Writeback beats link on r31: the file commits the writeback last on the same edge.
    always_comb begin
        valor = dadosLeitura;
        if (endereco == 5'd0) begin
            valor = 32'd0;
        end else if (wb_escrita && (wb_endereco == endereco)) begin
            valor = wb_dados;
        end else if (link_escrita && (endereco == 5'd31)) begin
            valor = link_dados;
        end
    end

    always_comb begin
        estado_d = estado_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        usa_rt_d = usa_rt_q;
        op_rs_d  = op_rs_q;
        op_rt_d  = op_rt_q;
        if (descarta) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (req_valido) begin
                        estado_d = LE_RS;
                        rs_d     = req_rs;
                        rt_d     = req_rt;
                        usa_rt_d = req_usa_rt;
                    end
                end
                LE_RS: begin
                    op_rs_d = valor;
                    if (usa_rt_q) begin
                        estado_d = LE_RT;
                    end else begin
                        estado_d = ENTREGA;
                        op_rt_d  = 32'd0;
                    end
                end
                LE_RT: begin
                    op_rt_d  = valor;
                    estado_d = ENTREGA;
                end
                ENTREGA: begin
                    if (op_pronto) begin
                        estado_d = OCIOSO;
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            rs_q     <= 5'd0;
            rt_q     <= 5'd0;
            usa_rt_q <= 1'b0;
            op_rs_q  <= 32'd0;
            op_rt_q  <= 32'd0;
        end else begin
            estado_q <= estado_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            usa_rt_q <= usa_rt_d;
            op_rs_q  <= op_rs_d;
            op_rt_q  <= op_rt_d;
        end
    end

    assign enderecoLeitura = endereco;
    assign req_pronto      = (estado_q == OCIOSO) & ~descarta & ~reset;
    assign hazard          = (estado_q != OCIOSO);
    assign op_valido       = (estado_q == ENTREGA);
    assign op_rs           = op_rs_q;
    assign op_rt           = op_rt_q;
endmodule

// File: tb/tb_escalonador_leitura_banco.sv
// Bench for escalonador_leitura_banco: directed fetches plus randomized traffic
// checked against a transaction-level model of the operand-fetch rules.
module tb_escalonador_leitura_banco;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valido;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic        req_usa_rt;
    logic        req_pronto;
    logic        descarta;
    logic [4:0]  enderecoLeitura;
    logic [31:0] dadosLeitura;
    logic        wb_escrita;
    logic [4:0]  wb_endereco;
    logic [31:0] wb_dados;
    logic        link_escrita;
    logic [31:0] link_dados;
    logic        op_valido;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic        op_pronto;
    logic        hazard;

    logic [31:0] regs [32];
    logic        planWbE  [2];
    logic [4:0]  planWbA  [2];
    logic [31:0] planWbD  [2];
    logic        planLkE  [2];
    logic [31:0] planLkD  [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    assign dadosLeitura = regs[enderecoLeitura];

    escalonador_leitura_banco dut (
        .clock          (clock),
        .reset          (reset),
        .req_valido     (req_valido),
        .req_rs         (req_rs),
        .req_rt         (req_rt),
        .req_usa_rt     (req_usa_rt),
        .req_pronto     (req_pronto),
        .descarta       (descarta),
        .enderecoLeitura(enderecoLeitura),
        .dadosLeitura   (dadosLeitura),
        .wb_escrita     (wb_escrita),
        .wb_endereco    (wb_endereco),
        .wb_dados       (wb_dados),
        .link_escrita   (link_escrita),
        .link_dados     (link_dados),
        .op_valido      (op_valido),
        .op_rs          (op_rs),
        .op_rt          (op_rt),
        .op_pronto      (op_pronto),
        .hazard         (hazard)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs just after the rising edge, then lets them settle.
    task automatic applyStimulus(input logic reqV, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usa, input logic desc, input logic opP,
                                 input logic wbE, input logic [4:0] wbA, input logic [31:0] wbD,
                                 input logic lkE, input logic [31:0] lkD);
        @(posedge clock);
        #1;
        req_valido   = reqV;
        req_rs       = rs;
        req_rt       = rt;
        req_usa_rt   = usa;
        descarta     = desc;
        op_pronto    = opP;
        wb_escrita   = wbE;
        wb_endereco  = wbA;
        wb_dados     = wbD;
        link_escrita = lkE;
        link_dados   = lkD;
        #1;
    endtask

    task automatic applyNoise(input logic reqV, input logic desc, input logic opP);
        applyStimulus(reqV, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      desc, opP, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                      1'($urandom_range(0, 1)), $urandom);
    endtask

    task automatic clearPlan();
        for (int i = 0; i < 2; i++) begin
            planWbE[i] = 1'b0;
            planWbA[i] = 5'd0;
            planWbD[i] = 32'd0;
            planLkE[i] = 1'b0;
            planLkD[i] = 32'd0;
        end
    endtask

    // Value an instruction must see for register addr given the writes active while it is read.
    function automatic logic [31:0] refOperand(input logic [4:0] addr, input int idx);
        if (addr == 5'd0) return 32'd0;
        if (planWbE[idx] && planWbA[idx] == addr) return planWbD[idx];
        if (planLkE[idx] && addr == 5'd31) return planLkD[idx];
        return regs[addr];
    endfunction

    // flushAt: 0 none, 1 in the rs read, 2 in the rt read, 3 together with op_pronto on delivery.
    task automatic runFetch(input logic [4:0] rs, input logic [4:0] rt, input logic usa,
                            input int stall, input int flushAt);
        logic [31:0] expRs;
        logic [31:0] expRt;
        applyStimulus(1'b1, rs, rt, usa, 1'b0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), $urandom);
        checkOutput("idle_req_pronto", 32'(req_pronto), 32'd1);
        checkOutput("idle_hazard", 32'(hazard), 32'd0);
        checkOutput("idle_op_valido", 32'(op_valido), 32'd0);
        checkOutput("idle_endereco", 32'(enderecoLeitura), 32'd0);

        applyStimulus(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1,
                      1'(flushAt == 1), 1'b1, planWbE[0], planWbA[0], planWbD[0], planLkE[0], planLkD[0]);
        checkOutput("rs_endereco", 32'(enderecoLeitura), 32'(rs));
        checkOutput("rs_hazard", 32'(hazard), 32'd1);
        checkOutput("rs_op_valido", 32'(op_valido), 32'd0);
        checkOutput("rs_req_pronto", 32'(req_pronto), 32'd0);
        if (flushAt == 1) return;
        expRs = refOperand(rs, 0);
        expRt = 32'd0;

        if (usa) begin
            applyStimulus(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0,
                          1'(flushAt == 2), 1'b1, planWbE[1], planWbA[1], planWbD[1], planLkE[1], planLkD[1]);
            checkOutput("rt_endereco", 32'(enderecoLeitura), 32'(rt));
            checkOutput("rt_hazard", 32'(hazard), 32'd1);
            checkOutput("rt_op_valido", 32'(op_valido), 32'd0);
            if (flushAt == 2) return;
            expRt = refOperand(rt, 1);
        end

        for (int s = 0; s <= stall; s++) begin
            applyNoise(1'b1, 1'(flushAt == 3 && s == stall), 1'(s == stall));
            checkOutput("ent_op_valido", 32'(op_valido), 32'd1);
            checkOutput("ent_op_rs", op_rs, expRs);
            checkOutput("ent_op_rt", op_rt, expRt);
            checkOutput("ent_hazard", 32'(hazard), 32'd1);
            checkOutput("ent_req_pronto", 32'(req_pronto), 32'd0);
        end
    endtask

    task automatic randomPlan(input logic [4:0] target, input int idx);
        case ($urandom_range(0, 3))
            0:       planWbA[idx] = target;
            1:       planWbA[idx] = 5'd31;
            2:       planWbA[idx] = 5'd0;
            default: planWbA[idx] = 5'($urandom_range(0, 31));
        endcase
        planWbE[idx] = 1'($urandom_range(0, 1));
        planWbD[idx] = $urandom;
        planLkE[idx] = 1'($urandom_range(0, 1));
        planLkD[idx] = $urandom;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] rs;
        logic [4:0] rt;
        int         f;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        clearPlan();
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("rst_op_valido", 32'(op_valido), 32'd0);
        checkOutput("rst_op_rs", op_rs, 32'd0);
        checkOutput("rst_op_rt", op_rt, 32'd0);
        checkOutput("rst_hazard", 32'(hazard), 32'd0);
        checkOutput("rst_endereco", 32'(enderecoLeitura), 32'd0);
        checkOutput("rst_req_pronto", 32'(req_pronto), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rel_req_pronto", 32'(req_pronto), 32'd1);
        checkOutput("rel_hazard", 32'(hazard), 32'd0);

        $display("[TB] two-operand fetch");
        regs[5] = 32'h11;
        regs[6] = 32'h22;
        runFetch(5'd5, 5'd6, 1'b1, 0, 0);

        $display("[TB] single operand");
        regs[7] = 32'hABCD;
        runFetch(5'd7, 5'd3, 1'b0, 0, 0);

        $display("[TB] r0 and forwarding");
        planWbE[0] = 1'b1; planWbA[0] = 5'd0; planWbD[0] = 32'hFFFF;
        runFetch(5'd0, 5'd4, 1'b0, 0, 0);
        clearPlan();
        regs[9] = 32'd0;
        planWbE[1] = 1'b1; planWbA[1] = 5'd9; planWbD[1] = 32'h1234;
        runFetch(5'd2, 5'd9, 1'b1, 0, 0);
        clearPlan();
        planWbE[0] = 1'b1; planWbA[0] = 5'd31; planWbD[0] = 32'hBBBB;
        planLkE[0] = 1'b1; planLkD[0] = 32'hAAAA;
        runFetch(5'd31, 5'd1, 1'b0, 0, 0);
        clearPlan();
        planLkE[0] = 1'b1; planLkD[0] = 32'hAAAA;
        planLkE[1] = 1'b1; planLkD[1] = 32'hCCCC;
        runFetch(5'd31, 5'd31, 1'b1, 0, 0);
        clearPlan();

        $display("[TB] backpressure and flush");
        runFetch(5'd5, 5'd6, 1'b1, 5, 3);
        runFetch(5'd6, 5'd5, 1'b1, 0, 1);
        runFetch(5'd7, 5'd6, 1'b1, 0, 2);
        runFetch(5'd8, 5'd9, 1'b0, 2, 0);

        $display("[TB] flush while idle blocks acceptance");
        applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("idle_flush_req_pronto", 32'(req_pronto), 32'd0);
        runFetch(5'd6, 5'd7, 1'b1, 0, 0);

        $display("[TB] reset during rt read");
        applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("midrst_pre_endereco", 32'(enderecoLeitura), 32'd6);
        reset = 1'b1;
        #1;
        checkOutput("midrst_op_valido", 32'(op_valido), 32'd0);
        checkOutput("midrst_op_rs", op_rs, 32'd0);
        checkOutput("midrst_op_rt", op_rt, 32'd0);
        checkOutput("midrst_hazard", 32'(hazard), 32'd0);
        checkOutput("midrst_endereco", 32'(enderecoLeitura), 32'd0);
        checkOutput("midrst_req_pronto", 32'(req_pronto), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst_rel_req_pronto", 32'(req_pronto), 32'd1);
        checkOutput("midrst_rel_hazard", 32'(hazard), 32'd0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 40; n++) begin
            for (int i = 1; i < 32; i++) regs[i] = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0) : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0) : 5'($urandom_range(0, 31));
            randomPlan(rs, 0);
            randomPlan(rt, 1);
            f = ($urandom_range(0, 7) < 5) ? 0 : int'($urandom_range(1, 3));
            runFetch(rs, rt, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), f);
        end
        clearPlan();
        runFetch(5'd5, 5'd6, 1'b1, 0, 0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        checkOutput("end_op_valido", 32'(op_valido), 32'd0);
        checkOutput("end_hazard", 32'(hazard), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/escalonador_leitura_banco.md
# escalonador_leitura_banco

Sequencer for the register file's single read port. Accepts an operand-fetch request from the ID stage and reads rs, then rt when needed, over consecutive cycles. It forwards any same-cycle writeback or link write and presents both 32-bit operands to EX with a valid/ready handshake. While busy it drives `hazard`, which stalls the ID stage and the control unit.

## Interface

- No parameters; widths are fixed (32 registers × 32 bits, 5-bit addresses).

Ports:

- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valido` in 1: ID has an instruction needing operands.
- `req_rs` in 5: first source register.
- `req_rt` in 5: second source register.
- `req_usa_rt` in 1: instruction needs rt.
- `req_pronto` out 1: request accepted this cycle when `req_valido & req_pronto`.
- `descarta` in 1: flush; abort any operation in progress.
- `enderecoLeitura` out 5: read address to the register file.
- `dadosLeitura` in 32: register file read data, combinational from `enderecoLeitura`.
- `wb_escrita` in 1: writeback writes the register file this cycle.
- `wb_endereco` in 5: writeback destination register.
- `wb_dados` in 32: writeback data.
- `link_escrita` in 1: link write to r31 this cycle.
- `link_dados` in 32: link data.
- `op_valido` out 1: operands valid for EX.
- `op_rs` out 32: rs operand.
- `op_rt` out 32: rt operand.
- `op_pronto` in 1: EX accepts operands this cycle.
- `hazard` out 1: stall ID and the control unit.

## Operation

- FSM states:
  - OCIOSO: `req_pronto = ~descarta`; `enderecoLeitura = 0`. On accept, latch rs, rt and usa_rt; go to LE_RS.
  - LE_RS: `enderecoLeitura = rs_latched`. Capture value V into `op_rs`. Next state is LE_RT if usa_rt, else ENTREGA with `op_rt <= 0`.
  - LE_RT: `enderecoLeitura = rt_latched`. Capture V into `op_rt`; go to ENTREGA.
  - ENTREGA: `op_valido = 1`. Operands held stable. On `op_pronto`, go to OCIOSO.
- Captured value V for address A, evaluated in priority order:
  - A == 0: V = 0 (r0 reads zero regardless of write inputs).
  - `wb_escrita & wb_endereco == A`: V = `wb_dados`.
  - `link_escrita & A == 31`: V = `link_dados`.
  - Otherwise: V = `dadosLeitura`.
- Writeback beats link on r31 because the register file commits the writeback after the link write on the same edge.
- `hazard` = (state != OCIOSO). `req_pronto` = (state == OCIOSO) & ~descarta & ~reset.
- `descarta` from any state forces OCIOSO at the next edge. `op_valido` drops that edge. `op_rs`/`op_rt` keep their values but are meaningless.
- `descarta` has priority over `op_pronto` and over acceptance.
- `op_rs`/`op_rt` change only on the capture edges in LE_RS/LE_RT.

## Timing

- Reset (asynchronous) sets:
  - state OCIOSO;
  - `op_valido` 0, `op_rs` 0, `op_rt` 0, `hazard` 0, `enderecoLeitura` 0, `req_pronto` 0.
- `req_pronto` rises combinationally once reset deasserts.
- Cycle numbering: accept edge = cycle 0.
  - LE_RS occupies cycle 1.
  - With rt: LE_RT in cycle 2, `op_valido` from cycle 3.
  - Without rt: `op_valido` from cycle 2.
- Minimum issue interval is 4 cycles with rt and 3 without, including the cycle ENTREGA→OCIOSO. No back-to-back accept from ENTREGA.
- `op_valido` stays high until the `op_pronto` edge; EX backpressure holds ENTREGA indefinitely.
- `hazard` is high from cycle 1 through the cycle of the `op_pronto` edge, inclusive.
- Write forwarding compares only in the capture cycle. A write to rs after LE_RS is not seen; the pipeline hazard logic handles that case.
- `reset` mid-operation: immediate return to reset values, no operand delivery.

## Test plan

- **Reset:** assert reset mid-LE_RT → all outputs 0 immediately, state OCIOSO. Deassert → `req_pronto` = 1, `hazard` = 0.
- **Two-operand fetch:** r5 = 0x11, r6 = 0x22; request rs = 5, rt = 6, usa_rt = 1, `op_pronto` tied 1.
  - `enderecoLeitura` = 5 at cycle 1 and 6 at cycle 2.
  - `op_valido` at cycle 3 with 0x11/0x22.
  - `hazard` high for cycles 1–3.
- **Single operand:** rs = 7 (0xABCD), usa_rt = 0 → `op_valido` at cycle 2, `op_rs` = 0xABCD, `op_rt` = 0.
- **r0 and forwarding:**
  - rs = 0 while wb writes r0 = 0xFFFF → `op_rs` = 0.
  - rt = 9 while wb writes r9 = 0x1234 in the LE_RT cycle (file still holds 0) → `op_rt` = 0x1234.
  - rs = 31 with link = 0xAAAA and wb r31 = 0xBBBB in the same cycle → `op_rs` = 0xBBBB.
- **Backpressure and flush:**
  - Hold `op_pronto` = 0 for 5 cycles in ENTREGA → `op_valido` and operands stable, `req_valido` not accepted.
  - Assert `descarta` with `op_pronto` = 1 → OCIOSO, `op_valido` 0 next cycle.
- **Flush mid-read:** `descarta` in LE_RS → OCIOSO next edge, `op_valido` never asserts; a new request is accepted the following cycle.
